seg7_scan_decoder: RTL and testbench

SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

---
 rtl/seg7_scan_decoder.sv | 260 ++++++++++++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
// Recovers the number shown on a multiplexed, active-low 4-digit 7-segment
// display by snooping its segment and anode lines. Each digit slot is
// captured once its lines have been stable for SETTLE_CYCLES cycles. A frame
// is published only when all four positions have been seen without a bad
// segment pattern.

module seg7_scan_decoder #(
    parameter int SETTLE_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        a,
    input  logic        b,
    input  logic        c,
    input  logic        d,
    input  logic        e,
    input  logic        f,
    input  logic        g,
    input  logic        dp,
    input  logic [3:0]  an,
    output logic [15:0] value,
    output logic [3:0]  dp_mask,
    output logic        frame_valid,
    output logic        digit_err,
    output logic        frame_err
);

    // ------------------------------------------------------------------
    // Local types and constants
    // ------------------------------------------------------------------

    // Result of decoding one segment pattern.
    typedef struct packed {
        logic       ok;
        logic [3:0] digit;
    } seg_dec_t;

    // The counter saturates at SETTLE_CYCLES, so 8 bits covers the legal range.
    localparam logic [7:0] SETTLE_MAX = 8'(SETTLE_CYCLES);
    localparam logic [7:0] SETTLE_M1  = 8'(SETTLE_CYCLES - 1);

    // Idle value of the sampled bus: all lines inactive (high).
    localparam logic [11:0] BUS_IDLE = 12'hFFF;

    // Map an active-low {g,f,e,d,c,b,a} pattern to a BCD digit.
    function automatic seg_dec_t seg_decode(input logic [6:0] seg);
        seg_dec_t r;
        r.ok    = 1'b1;
        r.digit = 4'h0;
        case (seg)
            7'b1000000: r.digit = 4'd0;
            7'b1111001: r.digit = 4'd1;
            7'b0100100: r.digit = 4'd2;
            7'b0110000: r.digit = 4'd3;
            7'b0011001: r.digit = 4'd4;
            7'b0010010: r.digit = 4'd5;
            7'b0000010: r.digit = 4'd6;
            7'b1111000: r.digit = 4'd7;
            7'b0000000: r.digit = 4'd8;
            7'b0010000: r.digit = 4'd9;
            default: begin
                r.ok    = 1'b0;
                r.digit = 4'hF;
            end
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Input sampling and stability tracking
    // ------------------------------------------------------------------

    // Bus layout: [11:8] anodes, [7:1] segments g..a, [0] decimal point.
    logic [11:0] in_q;
    logic [11:0] prev_q;
    logic [7:0]  cnt_q;
    logic [7:0]  cnt_d;
    logic        stable;
    logic        capture;

    // Register the raw display lines once; everything downstream uses in_q.
    // NOTE: registers are written with <= so every flop samples the values that existed before the edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            in_q   <= BUS_IDLE;
            prev_q <= BUS_IDLE;
            cnt_q  <= 8'd0;
        end else begin
            in_q   <= {an, g, f, e, d, c, b, a, dp};
            prev_q <= in_q;
            cnt_q  <= cnt_d;
        end
    end

    // Saturating stability counter; restarts whenever the sampled bus changes.
    // NOTE: every signal driven here gets a default first so no latch can be inferred.
    always_comb begin
        stable = (in_q == prev_q);
        cnt_d  = cnt_q;
        if (!stable) begin
            cnt_d = 8'd0;
        end else if (cnt_q != SETTLE_MAX) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // The capture fires only on the step into SETTLE_MAX, so at most once per hold.
    assign capture = stable && (cnt_q == SETTLE_M1);

    // ------------------------------------------------------------------
    // Capture classification
    // ------------------------------------------------------------------

    logic [3:0] cap_an;
    logic [6:0] cap_seg;
    logic       cap_dp_n;
    logic       an_blank;
    logic       an_one_low;
    logic [1:0] cap_pos;
    seg_dec_t   cap_dec;

    assign cap_an   = in_q[11:8];
    assign cap_seg  = in_q[7:1];
    assign cap_dp_n = in_q[0];
    assign cap_dec  = seg_decode(cap_seg);

    // Classify the anode pattern: blank, exactly one digit selected, or several.
    always_comb begin
        an_blank   = (cap_an == 4'b1111);
        an_one_low = 1'b1;
        cap_pos    = 2'd0;
        case (cap_an)
            4'b1110: cap_pos = 2'd0;
            4'b1101: cap_pos = 2'd1;
            4'b1011: cap_pos = 2'd2;
            4'b0111: cap_pos = 2'd3;
            default: an_one_low = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Frame assembly: shadow slots, seen mask, bad flag
    // ------------------------------------------------------------------

    logic [3:0][3:0] shadow_q;
    logic [3:0][3:0] shadow_d;
    logic [3:0]      shadow_dp_q;
    logic [3:0]      shadow_dp_d;
    logic [3:0]      seen_q;
    logic [3:0]      seen_d;
    logic            bad_q;
    logic            bad_d;
    logic            digit_err_q;
    logic            digit_err_d;
    logic            frame_done;

    // A frame completes on the cycle the seen mask is full.
    assign frame_done = (seen_q == 4'b1111);

    // Next-state for the shadow frame: clear after completion, then apply a capture.
    always_comb begin
        shadow_d    = shadow_q;
        shadow_dp_d = shadow_dp_q;
        seen_d      = seen_q;
        bad_d       = bad_q;
        digit_err_d = 1'b0;

        if (frame_done) begin
            seen_d = 4'b0000;
            bad_d  = 1'b0;
        end

        if (capture && !an_blank) begin
            if (!an_one_low) begin
                // Several digits driven at once: reject, record nothing.
                digit_err_d = 1'b1;
            end else if (cap_dec.ok) begin
                shadow_d[cap_pos]    = cap_dec.digit;
                shadow_dp_d[cap_pos] = ~cap_dp_n;
                seen_d[cap_pos]      = 1'b1;
            end else begin
                // Unknown glyph: the position counts as seen but poisons the frame.
                digit_err_d     = 1'b1;
                seen_d[cap_pos] = 1'b1;
                bad_d           = 1'b1;
            end
        end
    end

    // Shadow frame registers.
    // NOTE: the shadow slots are reset as well, so a frame never publishes power-up garbage.
    always_ff @(posedge clock) begin
        if (reset) begin
            shadow_q    <= '1;
            shadow_dp_q <= 4'b0000;
            seen_q      <= 4'b0000;
            bad_q       <= 1'b0;
            digit_err_q <= 1'b0;
        end else begin
            shadow_q    <= shadow_d;
            shadow_dp_q <= shadow_dp_d;
            seen_q      <= seen_d;
            bad_q       <= bad_d;
            digit_err_q <= digit_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Published frame
    // ------------------------------------------------------------------

    logic [15:0] value_q;
    logic [15:0] value_d;
    logic [3:0]  dp_mask_q;
    logic [3:0]  dp_mask_d;
    logic        frame_valid_q;
    logic        frame_valid_d;
    logic        frame_err_q;
    logic        frame_err_d;

    // Publish a clean frame or flag a poisoned one; the two pulses are exclusive.
    always_comb begin
        value_d       = value_q;
        dp_mask_d     = dp_mask_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        if (frame_done) begin
            if (!bad_q) begin
                value_d       = shadow_q;
                dp_mask_d     = shadow_dp_q;
                frame_valid_d = 1'b1;
            end else begin
                frame_err_d = 1'b1;
            end
        end
    end

    // Output registers; value and dp_mask hold until the next clean frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            value_q       <= 16'h0000;
            dp_mask_q     <= 4'b0000;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            value_q       <= value_d;
            dp_mask_q     <= dp_mask_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign value       = value_q;
    assign dp_mask     = dp_mask_q;
    assign frame_valid = frame_valid_q;
    assign digit_err   = digit_err_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Testbench for seg7_scan_decoder: a behavioural model turns each hold of
// the display lines into expected output pulses, a monitor pops and compares
// them as the DUT produces pulses.

module tb_seg7_scan_decoder;

    localparam int SETTLE = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        a, b, c, d, e, f, g, dp;
    logic [3:0]  an;
    logic [15:0] value;
    logic [3:0]  dp_mask;
    logic        frame_valid;
    logic        digit_err;
    logic        frame_err;

    always #5 clock = ~clock;

    seg7_scan_decoder #(.SETTLE_CYCLES(SETTLE)) dut (
        .clock       (clock),
        .reset       (reset),
        .a           (a),
        .b           (b),
        .c           (c),
        .d           (d),
        .e           (e),
        .f           (f),
        .g           (g),
        .dp          (dp),
        .an          (an),
        .value       (value),
        .dp_mask     (dp_mask),
        .frame_valid (frame_valid),
        .digit_err   (digit_err),
        .frame_err   (frame_err)
    );

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------

    typedef enum logic [1:0] {EV_DIGIT_ERR, EV_FRAME_VALID, EV_FRAME_ERR} ev_kind_t;

    typedef struct packed {
        ev_kind_t    kind;
        logic [15:0] value;
        logic [3:0]  dp_mask;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks     = 0;
    int  n_fail       = 0;
    int  pulse_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------

    logic [6:0]  seg_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                  7'b0000000, 7'b0010000};
    logic [3:0]  m_digit [4];
    bit          m_dp    [4];
    bit          m_seen  [4];
    bit          m_bad;
    logic [15:0] m_value;
    logic [3:0]  m_dp_mask;

    task automatic push_event(input ev_kind_t k);
        ev_t ev;
        ev.kind    = k;
        ev.value   = m_value;
        ev.dp_mask = m_dp_mask;
        exp_q.push_back(ev);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_seen[i] = 0;
        end
        m_bad     = 0;
        m_value   = 16'h0000;
        m_dp_mask = 4'b0000;
    endtask

    // One settled display state: decide what the decoder must do with it.
    task automatic model_capture(input logic [3:0] an_v, input logic [6:0] seg_v, input logic dp_v);
        int lows = 0;
        int pos  = 0;
        int dig  = -1;
        for (int i = 0; i < 4; i++) begin
            if (!an_v[i]) begin
                lows++;
                pos = i;
            end
        end
        if (lows == 0) return;
        if (lows > 1) begin
            push_event(EV_DIGIT_ERR);
            return;
        end
        for (int k = 0; k < 10; k++) begin
            if (seg_tbl[k] == seg_v) dig = k;
        end
        m_seen[pos] = 1;
        if (dig < 0) begin
            push_event(EV_DIGIT_ERR);
            m_bad = 1;
        end else begin
            m_digit[pos] = 4'(dig);
            m_dp[pos]    = !dp_v;
        end
        if (m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3]) begin
            if (!m_bad) begin
                m_value   = {m_digit[3], m_digit[2], m_digit[1], m_digit[0]};
                m_dp_mask = {m_dp[3], m_dp[2], m_dp[1], m_dp[0]};
                push_event(EV_FRAME_VALID);
            end else begin
                push_event(EV_FRAME_ERR);
            end
            for (int i = 0; i < 4; i++) begin
                m_seen[i] = 0;
            end
            m_bad = 0;
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus helpers (called at a falling edge)
    // ------------------------------------------------------------------

    // Hold one display state for n rising edges; it settles when n > SETTLE.
    task automatic hold(input logic [3:0] an_v, input logic [6:0] seg_v, input logic dp_v, input int n);
        if (n >= SETTLE + 1) model_capture(an_v, seg_v, dp_v);
        an = an_v;
        {g, f, e, d, c, b, a} = seg_v;
        dp = dp_v;
        repeat (n) @(negedge clock);
    endtask

    task automatic blank(input int n);
        hold(4'b1111, 7'b1111111, 1'b1, n);
    endtask

    // Scan an[3] down to an[0]; dp_low selects which positions show a point.
    task automatic scan4(input int d3, input int d2, input int d1, input int d0,
                         input logic [3:0] dp_low, input int n);
        hold(4'b0111, seg_tbl[d3], !dp_low[3], n);
        hold(4'b1011, seg_tbl[d2], !dp_low[2], n);
        hold(4'b1101, seg_tbl[d1], !dp_low[1], n);
        hold(4'b1110, seg_tbl[d0], !dp_low[0], n);
    endtask

    task automatic do_reset(input int n);
        blank(4);
        reset = 1'b1;
        repeat (n) @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    // ------------------------------------------------------------------
    // Monitor: every pulse cycle must match the oldest expected event
    // ------------------------------------------------------------------

    always @(negedge clock) begin
        if (frame_valid === 1'b1 || frame_err === 1'b1 || digit_err === 1'b1) begin
            pulse_cycles++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: got de/fv/fe=%b%b%b, expected none (t=%0t)",
                         digit_err, frame_valid, frame_err, $time);
            end else begin
                ev_t        ev;
                logic [2:0] exp_pulse;
                ev = exp_q.pop_front();
                case (ev.kind)
                    EV_DIGIT_ERR:   exp_pulse = 3'b100;
                    EV_FRAME_VALID: exp_pulse = 3'b010;
                    default:        exp_pulse = 3'b001;
                endcase
                check("pulse_kind(de,fv,fe)", {29'd0, digit_err, frame_valid, frame_err}, {29'd0, exp_pulse});
                check("value_at_pulse", {16'd0, value}, {16'd0, ev.value});
                check("dp_mask_at_pulse", {28'd0, dp_mask}, {28'd0, ev.dp_mask});
            end
        end
    end

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------

    initial begin
        int p0;
        reset = 1'b1;
        an = 4'hF; {g, f, e, d, c, b, a} = 7'h7F; dp = 1'b1;
        model_reset();
        @(negedge clock);

        // Reset held 10 cycles under random inputs, then quiet after release.
        for (int i = 0; i < 10; i++) begin
            an = 4'($urandom);
            {g, f, e, d, c, b, a} = 7'($urandom);
            dp = 1'($urandom);
            @(negedge clock);
        end
        reset = 1'b0;
        an = 4'hF; {g, f, e, d, c, b, a} = 7'h7F; dp = 1'b1;
        check("reset_value", {16'd0, value}, 32'h0);
        check("reset_dp_mask", {28'd0, dp_mask}, 32'h0);
        check("reset_frame_valid", {31'd0, frame_valid}, 32'h0);
        check("reset_digit_err", {31'd0, digit_err}, 32'h0);
        check("reset_frame_err", {31'd0, frame_err}, 32'h0);
        p0 = pulse_cycles;
        repeat (SETTLE + 2) @(negedge clock);
        check("quiet_after_reset", pulse_cycles - p0, 0);

        // Clean scan 1,2,3,4 with a point on an[1].
        do_reset(2);
        p0 = pulse_cycles;
        scan4(1, 2, 3, 4, 4'b0010, 20);
        blank(4);
        check("scan_1234_pulses", pulse_cycles - p0, 1);
        check("scan_1234_value", {16'd0, value}, 32'h1234);
        check("scan_1234_dp_mask", {28'd0, dp_mask}, 32'h2);

        // an[2] held too briefly: no frame. Leftover seen bits from that
        // partial scan complete a frame early during the first 9,8,7,6 scan,
        // so a second scan is needed to publish 9876.
        do_reset(2);
        p0 = pulse_cycles;
        hold(4'b0111, seg_tbl[1], 1'b1, 20);
        hold(4'b1011, seg_tbl[2], 1'b1, 10);
        blank(20);
        hold(4'b1101, seg_tbl[3], 1'b1, 20);
        hold(4'b1110, seg_tbl[4], 1'b1, 20);
        blank(4);
        check("short_hold_no_frame", pulse_cycles - p0, 0);
        scan4(9, 8, 7, 6, 4'b0000, 20);
        scan4(9, 8, 7, 6, 4'b0000, 20);
        blank(4);
        check("rescan_9876_value", {16'd0, value}, 32'h9876);

        // Bad glyph on an[0] after a good frame: digit_err then frame_err.
        do_reset(2);
        scan4(1, 2, 3, 4, 4'b0000, 20);
        p0 = pulse_cycles;
        hold(4'b0111, seg_tbl[1], 1'b1, 20);
        hold(4'b1011, seg_tbl[2], 1'b1, 20);
        hold(4'b1101, seg_tbl[3], 1'b1, 20);
        hold(4'b1110, 7'b1111111, 1'b1, 20);
        blank(4);
        check("bad_glyph_pulses", pulse_cycles - p0, 2);
        check("bad_glyph_value_held", {16'd0, value}, 32'h1234);

        // Two anodes low: one digit_err, seen mask untouched.
        do_reset(2);
        p0 = pulse_cycles;
        hold(4'b0011, seg_tbl[5], 1'b1, 20);
        blank(4);
        hold(4'b0111, seg_tbl[4], 1'b1, 20);
        hold(4'b1011, seg_tbl[3], 1'b1, 20);
        hold(4'b1101, seg_tbl[2], 1'b1, 20);
        blank(4);
        check("multi_anode_pulses", pulse_cycles - p0, 1);
        hold(4'b1110, seg_tbl[1], 1'b0, 20);
        blank(4);
        check("multi_anode_then_frame", {16'd0, value}, 32'h4321);

        // Reset mid-frame discards the partial capture.
        do_reset(2);
        hold(4'b0111, seg_tbl[5], 1'b1, 20);
        hold(4'b1011, seg_tbl[6], 1'b1, 20);
        do_reset(1);
        p0 = pulse_cycles;
        scan4(5, 6, 7, 8, 4'b0000, 20);
        blank(4);
        check("reset_midframe_pulses", pulse_cycles - p0, 1);
        check("reset_midframe_value", {16'd0, value}, 32'h5678);

        // Settle boundary: SETTLE cycles is too short, SETTLE+1 captures.
        do_reset(2);
        hold(4'b1110, seg_tbl[9], 1'b1, SETTLE);
        blank(4);
        scan4(2, 0, 2, 5, 4'b1001, SETTLE + 1);
        blank(4);
        check("boundary_value", {16'd0, value}, 32'h2025);
        check("boundary_dp_mask", {28'd0, dp_mask}, 32'h9);

        // Randomized holds around the settle threshold.
        do_reset(2);
        for (int it = 0; it < 80; it++) begin
            logic [3:0] an_v;
            logic [3:0] one;
            logic [6:0] seg_v;
            int         r;
            int         i0;
            int         i1;
            one = 4'b0001;
            r   = int'($urandom_range(0, 9));
            i0  = int'($urandom_range(0, 3));
            if (r == 0) begin
                an_v = 4'b1111;
            end else if (r == 1) begin
                i1   = (i0 + 1 + int'($urandom_range(0, 2))) % 4;
                an_v = ~((one << i0) | (one << i1));
            end else begin
                an_v = ~(one << i0);
            end
            if ($urandom_range(0, 9) == 0) seg_v = 7'($urandom);
            else                           seg_v = seg_tbl[$urandom_range(0, 9)];
            hold(an_v, seg_v, 1'($urandom), int'($urandom_range(SETTLE - 2, SETTLE + 5)));
            blank(2);
        end
        blank(6);

        check("all_expected_seen", exp_q.size(), 0);
        check("final_value", {16'd0, value}, {16'd0, m_value});
        check("final_dp_mask", {28'd0, dp_mask}, {28'd0, m_dp_mask});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
